mc_datapath: RTL and testbench
==============================

# mc_datapath

Multicycle MIPS datapath: the datapath that consumes the control unit's per-cycle strobes and returns the current instruction's `opcode`/`funct`. It holds:

- the architectural state: PC and the 32×32 register file;
- the inter-cycle registers: Instr, Data, A, B, ALUOut;
- the ALU.

It drives a single unified instruction/data memory with combinational read. Together with the control unit, it forms the complete CPU core.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset

Ports:
- `clk`  in  1  core clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- `mem_to_reg`  in  1  regfile write data: 0=ALUOut, 1=Data
- `reg_dest`  in  1  regfile write address: 0=rt (Instr[20:16]), 1=rd (Instr[15:11])
- `i_or_d`  in  1  memory address: 0=PC, 1=ALUOut
- `alu_src_a`  in  1  ALU A: 0=PC, 1=A
- `alu_src_b`  in  2  ALU B: 00=B, 01=32'd4, 10=SignImm, 11=SignImm<<2
- `ir_write`  in  1  load Instr from `mem_rdata`
- `mem_write`  in  1  passed through to `mem_we`
- `pc_write`  in  1  unconditional PC load
- `branch`  in  1  PC load if ALU zero
- `reg_write`  in  1  regfile write enable
- `pc_src`  in  2  next-PC: 00=ALU result, 01=ALUOut, 10=jump target (see Configuration)
- `alu_control`  in  3  010 add, 110 sub, 000 and, 001 or, 111 slt; others yield 0
- `mem_rdata`  in  32  memory read data, valid same cycle as `mem_addr`
- `mem_addr`  out  32  byte address
- `mem_wdata`  out  32  = B register
- `mem_we`  out  1  = `mem_write`
- `opcode`  out  6  = Instr[31:26]
- `funct`  out  6  = Instr[5:0]
- `pc`  out  32  current PC (debug/observation)

## Operation
- Reset (`reset`=0, asynchronous):
  - PC=`RESET_PC`.
  - Instr, Data, A, B, ALUOut and all 32 registers = 0.
  - `opcode`/`funct`=0, `mem_we`=`mem_write`, `mem_addr`=`RESET_PC` when `i_or_d`=0.
- Every rising edge, not in reset:
  - Data ← `mem_rdata`.
  - A ← rf[Instr[25:21]]; B ← rf[Instr[20:16]].
  - ALUOut ← ALU result.
  - Instr ← `mem_rdata` only when `ir_write`.
- PC enable = `pc_write` | (`branch` & zero).
  - zero = (ALU result == 0), combinational from the current cycle's ALU result.
  - When enabled, PC ← the `pc_src`-selected value.
  - `pc_write` and `branch` together: PC loads regardless of zero.
- SignImm = {{16{Instr[15]}}, Instr[15:0]}. The shift-left-by-2 discards the upper 2 bits.
- ALU arithmetic is 32-bit modulo 2^32, with no overflow trap.
  - slt is signed: result = 32'd1 if $signed(A) < $signed(B), else 0.
- Register file:
  - two combinational read ports, one synchronous write port;
  - writes to register 0 are ignored, and reads of register 0 return 0;
  - a read in the same cycle as a write to the same register returns the old value (new value visible the next cycle).
- `pc_src`=11 is reserved and selects the ALU result.

## Timing
- `mem_addr`, `opcode`, `funct` and `mem_wdata` are combinational from registers and the control inputs only. They have no path from `mem_rdata`.
- Instruction fetch: `i_or_d`=0 and `ir_write`=1 in cycle N gives `opcode`/`funct` valid from cycle N+1.
- Register operands: A/B reflect the rf contents one cycle after Instr is loaded (decode cycle).
- Memory write: committed by the external memory on the edge ending the cycle in which `mem_we`=1. Address and data must be stable for the whole cycle, which holds because both come from registers.
- Reset released mid-instruction: the core restarts from `RESET_PC` with cleared state. No partial state survives.

## Configuration
- `MC_DATAPATH_JUMP_EN` defined:
  - `pc_src`=10 selects the jump target {PC[31:28], Instr[25:0], 2'b00}.
  - PC[31:28] is taken from the current PC register, which already holds PC+4 after fetch.
- Not defined:
  - `pc_src`=10 behaves as 00 (ALU result);
  - no jump-target logic is instantiated.

## Structure
- Shared package `mc_pkg` holds:
  - `alu_control` encoding constants;
  - `alu_src_b` and `pc_src` encoding constants;
  - `RESET_PC` default;
  - opcode constants (R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010), shared with the control unit.
- One sub-module, `mc_regfile`: 32×32, async active-low clear, two read ports, one write port, register 0 hardwired to zero.
- ALU is inline combinational logic in `mc_datapath`.

## Test plan
- Reset: hold `reset`=0, pulse `clk` → `pc`=`RESET_PC`, `opcode`=0, `funct`=0. Assert `reset` mid-run → `pc` returns to `RESET_PC` asynchronously, with no clock edge needed.
- Fetch: `mem_rdata`=32'h2008_0005 (addi $8,$0,5); drive fetch strobes (`ir_write`=1, `pc_write`=1, `alu_src_b`=01, add) → next cycle `opcode`=001000, `pc`=4. Execute/writeback with `reg_dest`=0 → rf[8]=5.
- R-type: rf[8]=5, rf[9]=7, Instr sub $10,$8,$9 → rf[10]=32'hFFFF_FFFE. Same with slt → rf[10]=1. Write to $0 → rf[0] stays 0.
- Memory: sw $9,8($0) → `mem_addr`=8, `mem_wdata`=7, `mem_we`=1 in the write cycle. lw with `mem_rdata`=32'hDEAD_BEEF → rt=32'hDEAD_BEEF.
- Branch: beq with equal operands, `branch`=1, `pc_src`=01, ALUOut=target 32'h40 → `pc`=32'h40. Unequal operands → PC unchanged.
- Jump: with `MC_DATAPATH_JUMP_EN`, PC=32'h1000_0004, Instr[25:0]=26'h10 → `pc`=32'h1000_0040. Without the macro → `pc` = ALU result.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS core: ALU operations, mux selects,
// reset PC default and the opcodes the control unit decodes.
package mc_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port, register 0 reads as zero and ignores writes.
module mc_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [32];

    // NOTE: the array is cleared on reset because the core must restart with no architectural state surviving.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write shows up next cycle.
    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: PC, register file, Instr/Data/A/B/ALUOut and ALU.
// Define MC_DATAPATH_JUMP_EN to make pc_src=10 select the j-type jump target.
module mc_datapath
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_to_reg,
    input  logic        reg_dest,
    input  logic        i_or_d,
    input  logic        alu_src_a,
    input  logic [1:0]  alu_src_b,
    input  logic        ir_write,
    input  logic        mem_write,
    input  logic        pc_write,
    input  logic        branch,
    input  logic        reg_write,
    input  logic [1:0]  pc_src,
    input  logic [2:0]  alu_control,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc
);

    logic [31:0] instr, data, a_q, b_q, alu_out;
    logic [31:0] rd1, rd2, sign_imm, src_a, src_b, alu_result, pc_next;
    logic        zero, pc_en;

    mc_regfile u_regfile (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (instr[25:21]),
        .raddr2 (instr[20:16]),
        .rdata1 (rd1),
        .rdata2 (rd2),
        .we     (reg_write),
        .waddr  (reg_dest ? instr[15:11] : instr[20:16]),
        .wdata  (mem_to_reg ? data : alu_out)
    );

    assign sign_imm = {{16{instr[15]}}, instr[15:0]};
    assign src_a    = alu_src_a ? a_q : pc;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        src_b = b_q;
        case (alu_src_b)
            SRCB_FOUR:   src_b = 32'd4;
            SRCB_IMM:    src_b = sign_imm;
            SRCB_IMM_SH: src_b = {sign_imm[29:0], 2'b00};
            default:     src_b = b_q;
        endcase
    end

    always_comb begin
        alu_result = 32'd0;
        case (alu_control)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
            default: alu_result = 32'd0;
        endcase
    end

    assign zero  = (alu_result == 32'd0);
    assign pc_en = pc_write | (branch & zero);

    always_comb begin
        pc_next = alu_result;
        case (pc_src)
            PC_SRC_ALUOUT: pc_next = alu_out;
`ifdef MC_DATAPATH_JUMP_EN
            PC_SRC_JUMP:   pc_next = {pc[31:28], instr[25:0], 2'b00};
`endif
            default:       pc_next = alu_result;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            instr   <= '0;
            data    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_out <= '0;
        end else begin
            data    <= mem_rdata;
            a_q     <= rd1;
            b_q     <= rd2;
            alu_out <= alu_result;
            if (ir_write) instr <= mem_rdata;
            if (pc_en)    pc    <= pc_next;
        end
    end

    // Outputs come from registers and control only; mem_rdata has no path to them.
    assign mem_addr  = i_or_d ? alu_out : pc;
    assign mem_wdata = b_q;
    assign mem_we    = mem_write;
    assign opcode    = instr[31:26];
    assign funct     = instr[5:0];

endmodule

// File: tb/tb_mc_datapath.sv
// Directed self-checking bench for mc_datapath: the bench plays the control
// unit cycle by cycle and observes registers through mem_addr/mem_wdata/pc.
module tb_mc_datapath;
    import mc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_to_reg, reg_dest, i_or_d, alu_src_a;
    logic [1:0]  alu_src_b;
    logic        ir_write, mem_write, pc_write, branch, reg_write;
    logic [1:0]  pc_src;
    logic [2:0]  alu_control;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr, mem_wdata, pc;
    logic        mem_we;
    logic [5:0]  opcode, funct;

    int vectors = 0;
    int miscompares = 0;

    mc_datapath dut (
        .clk         (clk),
        .reset       (reset),
        .mem_to_reg  (mem_to_reg),
        .reg_dest    (reg_dest),
        .i_or_d      (i_or_d),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .ir_write    (ir_write),
        .mem_write   (mem_write),
        .pc_write    (pc_write),
        .branch      (branch),
        .reg_write   (reg_write),
        .pc_src      (pc_src),
        .alu_control (alu_control),
        .mem_rdata   (mem_rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .opcode      (opcode),
        .funct       (funct),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_to_reg  = 1'b0;
        reg_dest    = 1'b0;
        i_or_d      = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        pc_write    = 1'b0;
        branch      = 1'b0;
        reg_write   = 1'b0;
        pc_src      = PC_SRC_ALU;
        alu_control = ALU_ADD;
    endtask

    // Load Instr without touching the PC.
    task automatic load_instr(input logic [31:0] ins);
        idle();
        mem_rdata = ins;
        ir_write  = 1'b1;
        cycle();
        idle();
    endtask

    // Register contents become visible on mem_wdata (B) one cycle after rt is set.
    task automatic read_reg(input logic [4:0] idx, output logic [31:0] val);
        load_instr({OP_RTYPE, 5'd0, idx, 16'd0});
        cycle();
        val = mem_wdata;
    endtask

    task automatic run_r(input logic [31:0] ins, input logic [2:0] op);
        load_instr(ins);
        cycle();
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_REG;
        alu_control = op;
        cycle();
        idle();
        reg_dest  = 1'b1;
        reg_write = 1'b1;
        cycle();
        idle();
    endtask

    task automatic run_addi(input logic [31:0] ins);
        load_instr(ins);
        cycle();
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        cycle();
        idle();
        reg_write = 1'b1;
        cycle();
        idle();
    endtask

    task automatic load_reg(input logic [4:0] idx, input logic [31:0] val);
        load_instr({OP_LW, 5'd0, idx, 16'd0});
        cycle();
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        cycle();
        idle();
        i_or_d    = 1'b1;
        mem_rdata = val;
        cycle();
        idle();
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        mem_write = 1'b1;
        #1;
        vectors++;
        if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
        vectors++;
        if (opcode !== 6'd0 || funct !== 6'd0) begin
            miscompares++; $display("FAIL reset_opfunct: got %b/%b expected 0/0", opcode, funct);
        end
        vectors++;
        if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr: got %h expected %h", mem_addr, 32'h0); end
        vectors++;
        if (mem_we !== 1'b1) begin miscompares++; $display("FAIL reset_mem_we: got %b expected 1", mem_we); end
        mem_write = 1'b0;
        v = mem_wdata;
        vectors++;
        if (v !== 32'h0) begin miscompares++; $display("FAIL reset_mem_wdata: got %h expected 0", v); end
    endtask

    task automatic test_fetch();
        logic [31:0] v;
        idle();
        mem_rdata = 32'h2008_0005;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        cycle();
        idle();
        vectors++;
        if (opcode !== OP_ADDI) begin miscompares++; $display("FAIL fetch_opcode: got %b expected %b", opcode, OP_ADDI); end
        vectors++;
        if (funct !== 6'b000101) begin miscompares++; $display("FAIL fetch_funct: got %b expected 000101", funct); end
        vectors++;
        if (pc !== 32'd4) begin miscompares++; $display("FAIL fetch_pc: got %h expected %h", pc, 32'd4); end
        cycle();
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        cycle();
        idle();
        reg_write = 1'b1;
        cycle();
        idle();
        read_reg(5'd8, v);
        vectors++;
        if (v !== 32'd5) begin miscompares++; $display("FAIL addi_rf8: got %h expected %h", v, 32'd5); end
        run_addi({OP_ADDI, 5'd0, 5'd9, 16'd7});
        read_reg(5'd9, v);
        vectors++;
        if (v !== 32'd7) begin miscompares++; $display("FAIL addi_rf9: got %h expected %h", v, 32'd7); end
    endtask

    task automatic test_rtype();
        logic [31:0] v;
        run_r({OP_RTYPE, 5'd8, 5'd9, 5'd10, 5'd0, 6'h22}, ALU_SUB);
        read_reg(5'd10, v);
        vectors++;
        if (v !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL sub_rf10: got %h expected %h", v, 32'hFFFF_FFFE); end
        run_r({OP_RTYPE, 5'd8, 5'd9, 5'd10, 5'd0, 6'h2A}, ALU_SLT);
        read_reg(5'd10, v);
        vectors++;
        if (v !== 32'd1) begin miscompares++; $display("FAIL slt_rf10: got %h expected %h", v, 32'd1); end
        run_r({OP_RTYPE, 5'd8, 5'd9, 5'd0, 5'd0, 6'h20}, ALU_ADD);
        read_reg(5'd0, v);
        vectors++;
        if (v !== 32'd0) begin miscompares++; $display("FAIL write_r0: got %h expected 0", v); end
        // add $10,$10,$9: A latched at the write edge must hold the old rf[10]=1.
        run_r({OP_RTYPE, 5'd10, 5'd9, 5'd10, 5'd0, 6'h20}, ALU_ADD);
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        cycle();
        idle();
        i_or_d = 1'b1;
        #1;
        vectors++;
        if (mem_addr !== 32'd8) begin miscompares++; $display("FAIL rf_read_old: got %h expected %h", mem_addr, 32'd8); end
        read_reg(5'd10, v);
        vectors++;
        if (v !== 32'd8) begin miscompares++; $display("FAIL add_rf10: got %h expected %h", v, 32'd8); end
    endtask

    task automatic test_memory();
        logic [31:0] v;
        load_instr({OP_SW, 5'd0, 5'd9, 16'd8});
        cycle();
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        cycle();
        idle();
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        #1;
        vectors++;
        if (mem_addr !== 32'd8) begin miscompares++; $display("FAIL sw_addr: got %h expected %h", mem_addr, 32'd8); end
        vectors++;
        if (mem_wdata !== 32'd7) begin miscompares++; $display("FAIL sw_wdata: got %h expected %h", mem_wdata, 32'd7); end
        vectors++;
        if (mem_we !== 1'b1) begin miscompares++; $display("FAIL sw_we: got %b expected 1", mem_we); end
        cycle();
        idle();
        load_instr({OP_LW, 5'd0, 5'd11, 16'd4});
        cycle();
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        cycle();
        idle();
        i_or_d    = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        vectors++;
        if (mem_addr !== 32'd4) begin miscompares++; $display("FAIL lw_addr: got %h expected %h", mem_addr, 32'd4); end
        cycle();
        idle();
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        cycle();
        idle();
        read_reg(5'd11, v);
        vectors++;
        if (v !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL lw_rf11: got %h expected %h", v, 32'hDEAD_BEEF); end
    endtask

    task automatic test_alu();
        // A = rf[11] = DEADBEEF (negative), B = rf[9] = 7
        logic [2:0]  ops [6] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, 3'b011};
        logic [31:0] exps [6] = '{32'h0000_0007, 32'hDEAD_BEEF, 32'hDEAD_BEF6,
                                  32'hDEAD_BEE8, 32'h0000_0001, 32'h0000_0000};
        logic [1:0]  srcs [2] = '{SRCB_IMM, SRCB_IMM_SH};
        logic [31:0] imm_exps [2] = '{32'h0000_0003, 32'hFFFF_FFF7};
        load_instr({OP_RTYPE, 5'd11, 5'd9, 16'd0});
        cycle();
        for (int i = 0; i < 6; i++) begin
            idle();
            alu_src_a   = 1'b1;
            alu_control = ops[i];
            cycle();
            i_or_d = 1'b1;
            #1;
            vectors++;
            if (mem_addr !== exps[i]) begin
                miscompares++; $display("FAIL alu_op_%b: got %h expected %h", ops[i], mem_addr, exps[i]);
            end
        end
        // A = rf[9] = 7, immediate = -4
        load_instr({OP_ADDI, 5'd9, 5'd0, 16'hFFFC});
        cycle();
        for (int i = 0; i < 2; i++) begin
            idle();
            alu_src_a = 1'b1;
            alu_src_b = srcs[i];
            cycle();
            i_or_d = 1'b1;
            #1;
            vectors++;
            if (mem_addr !== imm_exps[i]) begin
                miscompares++; $display("FAIL alu_srcb_%b: got %h expected %h", srcs[i], mem_addr, imm_exps[i]);
            end
        end
        idle();
    endtask

    task automatic test_branch();
        load_instr({OP_BEQ, 5'd8, 5'd8, 16'd15});
        alu_src_b = SRCB_IMM_SH;
        cycle();
        idle();
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        branch      = 1'b1;
        pc_src      = PC_SRC_ALUOUT;
        cycle();
        idle();
        vectors++;
        if (pc !== 32'h40) begin miscompares++; $display("FAIL beq_taken_pc: got %h expected %h", pc, 32'h40); end
        load_instr({OP_BEQ, 5'd8, 5'd9, 16'd15});
        alu_src_b = SRCB_IMM_SH;
        cycle();
        idle();
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        branch      = 1'b1;
        pc_src      = PC_SRC_ALUOUT;
        cycle();
        idle();
        vectors++;
        if (pc !== 32'h40) begin miscompares++; $display("FAIL beq_not_taken_pc: got %h expected %h", pc, 32'h40); end
        // pc_write with branch loads even though the result (5 & 7) is nonzero.
        alu_src_a   = 1'b1;
        alu_control = ALU_AND;
        branch      = 1'b1;
        pc_write    = 1'b1;
        cycle();
        idle();
        vectors++;
        if (pc !== 32'd5) begin miscompares++; $display("FAIL pcwrite_and_branch: got %h expected %h", pc, 32'd5); end
    endtask

    task automatic test_jump();
        logic [31:0] exp_pc;
        load_reg(5'd12, 32'h1000_0000);
        load_instr({OP_RTYPE, 5'd12, 5'd0, 16'd0});
        cycle();
        alu_src_a = 1'b1;
        pc_write  = 1'b1;
        cycle();
        idle();
        vectors++;
        if (pc !== 32'h1000_0000) begin miscompares++; $display("FAIL jump_setup_pc: got %h expected %h", pc, 32'h1000_0000); end
        mem_rdata = {OP_J, 26'h10};
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        cycle();
        idle();
        vectors++;
        if (opcode !== OP_J || pc !== 32'h1000_0004) begin
            miscompares++; $display("FAIL j_fetch: got %b/%h expected %b/%h", opcode, pc, OP_J, 32'h1000_0004);
        end
`ifdef MC_DATAPATH_JUMP_EN
        exp_pc = 32'h1000_0040;
`else
        exp_pc = 32'h1000_0008;
`endif
        pc_write  = 1'b1;
        pc_src    = PC_SRC_JUMP;
        alu_src_b = SRCB_FOUR;
        cycle();
        idle();
        vectors++;
        if (pc !== exp_pc) begin miscompares++; $display("FAIL jump_pc: got %h expected %h", pc, exp_pc); end
        pc_write  = 1'b1;
        pc_src    = 2'b11;
        alu_src_b = SRCB_FOUR;
        cycle();
        idle();
        vectors++;
        if (pc !== exp_pc + 32'd4) begin miscompares++; $display("FAIL pc_src_reserved: got %h expected %h", pc, exp_pc + 32'd4); end
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (pc !== 32'h0) begin miscompares++; $display("FAIL async_reset_pc: got %h expected %h", pc, 32'h0); end
        vectors++;
        if (opcode !== 6'd0 || mem_addr !== 32'h0) begin
            miscompares++; $display("FAIL async_reset_state: got %b/%h expected 0/0", opcode, mem_addr);
        end
        cycle();
        reset = 1'b1;
        read_reg(5'd8, v);
        vectors++;
        if (v !== 32'd0) begin miscompares++; $display("FAIL async_reset_rf8: got %h expected 0", v); end
        read_reg(5'd12, v);
        vectors++;
        if (v !== 32'd0) begin miscompares++; $display("FAIL async_reset_rf12: got %h expected 0", v); end
    endtask

    initial begin
        reset     = 1'b0;
        mem_rdata = 32'd0;
        idle();
        cycle();
        cycle();
        test_reset();
        reset = 1'b1;
        test_fetch();
        test_rtype();
        test_memory();
        test_alu();
        test_branch();
        test_jump();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
